// File: rtl/led_blink_ctrl.sv
// ---------------------------------------------------------------------------
// led_blink_ctrl
//
// Command-driven LED sequencer. A requester hands over one command at a time
// (valid/ready handshake) selecting OFF, ON, BLINK (continuous square wave)
// or BURST (a fixed number of high/low pulses followed by a one-cycle done
// pulse). A shared prescaler divides clk down to a tick and every pattern
// duration is counted in ticks, so the LED timing scales with TICK_DIV.
//
// Parameters
//   TICK_DIV  clk cycles per tick, must be >= 2
//   HALF_W    width of the half-period field (ticks)
//   CNT_W     width of the burst pulse-count field
//
// Ports
//   clk        sole clock, everything on the rising edge
//   rst_n      synchronous reset, active low
//   cmd_valid  a command is presented
//   cmd_ready  block will take a command this cycle (low only during BURST)
//   cmd_mode   0=OFF 1=ON 2=BLINK 3=BURST
//   cmd_half   half-period in ticks for BLINK/BURST, 0 behaves as 1
//   cmd_count  number of pulses for BURST
//   led        registered LED drive
//   busy       high while a BURST is running
//   done       one-cycle pulse when a BURST finishes
// ---------------------------------------------------------------------------
module led_blink_ctrl #(
   parameter int TICK_DIV = 100000,
   parameter int HALF_W   = 8,
   parameter int CNT_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_mode,
   input  logic [HALF_W-1:0] cmd_half,
   input  logic [CNT_W-1:0]  cmd_count,
   output logic              led,
   output logic              busy,
   output logic              done
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_ON    = 2'd1,
      S_BLINK = 2'd2,
      S_BURST = 2'd3
   } state_t;

   state_t            state;
   logic [PRE_W-1:0]  pre;
   logic [HALF_W-1:0] phase;
   logic [HALF_W-1:0] half_eff;
   logic [CNT_W-1:0]  pulse;
   logic [CNT_W-1:0]  count;

   logic tick;
   logic accept;
   logic phase_last;
   logic pulse_last;

   // Terminal values are compared before incrementing, so none of the
   // counters ever needs to wrap. half_eff is never 0 and pulse_last is only
   // consulted in BURST where count is never 0, so the "-1" cannot underflow.
   assign tick       = (pre == PRE_LAST);
   assign accept     = cmd_valid & cmd_ready;
   assign phase_last = (phase == (half_eff - HALF_W'(1)));
   assign pulse_last = (pulse == (count - CNT_W'(1)));

   // Single sequencer: the prescaler free-runs but restarts on every accepted
   // command so pattern timing is always measured from the accept edge.
   // A BURST pulse is a high half followed by a low half; the pulse counter
   // advances at the end of each low half and the burst ends there once the
   // requested number of pulses has been emitted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_OFF;
         led       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cmd_ready <= 1'b1;
         pre       <= '0;
         phase     <= '0;
         pulse     <= '0;
         half_eff  <= HALF_W'(1);
         count     <= '0;
      end else begin
         done <= 1'b0;
         pre  <= tick ? '0 : pre + PRE_W'(1);

         if (accept) begin
            pre      <= '0;
            phase    <= '0;
            pulse    <= '0;
            half_eff <= (cmd_half == '0) ? HALF_W'(1) : cmd_half;
            count    <= cmd_count;
            case (cmd_mode)
               2'd0: begin
                  state     <= S_OFF;
                  led       <= 1'b0;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
               end
               2'd1: begin
                  state     <= S_ON;
                  led       <= 1'b1;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
               end
               2'd2: begin
                  state     <= S_BLINK;
                  led       <= 1'b1;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
               end
               default: begin
                  // An empty burst completes immediately without any pulse.
                  if (cmd_count == '0) begin
                     state     <= S_OFF;
                     led       <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     cmd_ready <= 1'b1;
                  end else begin
                     state     <= S_BURST;
                     led       <= 1'b1;
                     busy      <= 1'b1;
                     cmd_ready <= 1'b0;
                  end
               end
            endcase
         end else if ((state == S_BLINK) || (state == S_BURST)) begin
            if (tick) begin
               if (phase_last) begin
                  phase <= '0;
                  if ((state == S_BURST) && !led) begin
                     if (pulse_last) begin
                        state     <= S_OFF;
                        led       <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                     end else begin
                        pulse <= pulse + CNT_W'(1);
                        led   <= 1'b1;
                     end
                  end else begin
                     led <= ~led;
                  end
               end else begin
                  phase <= phase + HALF_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_blink_ctrl
//
// Scoreboard bench for led_blink_ctrl with TICK_DIV=4. The driver issues one
// input vector per clock and pushes the expected {led,busy,done,cmd_ready}
// for the following cycle into a queue; a separate monitor pops one entry
// per cycle and compares it with the DUT outputs. Expected values come from
// a timeline model: each pattern is a function of the cycles elapsed since
// its command was accepted.
// ---------------------------------------------------------------------------
module tb_led_blink_ctrl;

   localparam int TD = 4;
   localparam int HW = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_mode = 2'd0;
   logic [HW-1:0] cmd_half = '0;
   logic [CW-1:0] cmd_count = '0;
   logic          led;
   logic          busy;
   logic          done;

   typedef struct packed {
      logic [3:0] v;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // Reference model state: active pattern and cycles since its accept.
   int m_mode = 0;
   int m_half = 1;
   int m_cnt = 0;
   int m_e = 0;
   bit m_ready = 1'b1;

   led_blink_ctrl #(
      .TICK_DIV(TD),
      .HALF_W  (HW),
      .CNT_W   (CW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_mode (cmd_mode),
      .cmd_half (cmd_half),
      .cmd_count(cmd_count),
      .led      (led),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Half-period in clk cycles for a given half field.
   function automatic int half_cycles(input int half);
      return ((half == 0) ? 1 : half) * TD;
   endfunction

   // Expected {led,busy,done,cmd_ready} e cycles after a command was taken.
   function automatic logic [3:0] ref_out(input int mode, input int half,
                                          input int cnt, input int e);
      int p;
      int total;
      bit high;
      p     = half_cycles(half);
      total = 2 * p * cnt;
      high  = ((e / p) % 2) == 0;
      case (mode)
         0:       return 4'b0001;
         1:       return 4'b1001;
         2:       return {high, 3'b001};
         default: begin
            if (e < total) return {high, 3'b100};
            else           return 4'b0011;
         end
      endcase
   endfunction

   // Drive one vector for the next rising edge and record what the DUT must
   // show after that edge.
   task automatic apply_stimulus(input bit r, input bit v, input int md,
                                 input int h, input int c);
      exp_t x;
      @(negedge clk);
      rst_n     = r;
      cmd_valid = v;
      cmd_mode  = md[1:0];
      cmd_half  = h[HW-1:0];
      cmd_count = c[CW-1:0];
      @(posedge clk);
      cyc++;
      if (!r) begin
         m_mode = 0;
         m_e    = 0;
      end else if (v && m_ready) begin
         m_mode = md;
         m_half = h;
         m_cnt  = c;
         m_e    = 0;
      end else if ((m_mode == 3) && (m_e >= 2 * half_cycles(m_half) * m_cnt)) begin
         m_mode = 0;
         m_e    = 0;
      end else begin
         m_e++;
      end
      x.v     = ref_out(m_mode, m_half, m_cnt, m_e);
      x.cyc   = cyc;
      m_ready = x.v[0];
      exp_q.push_back(x);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b0, 0, 0, 0);
   endtask

   task automatic check_output(input exp_t x);
      logic [3:0] got;
      got = {led, busy, done, cmd_ready};
      vectors++;
      if (got !== x.v) begin
         miscompares++;
         $display("[TB] FAIL outputs@cycle%0d {led,busy,done,ready} got %b expected %b",
                  x.cyc, got, x.v);
      end
   endtask

   // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) check_output(exp_q.pop_front());
   end

   initial begin
      // Reset with a command pending: nothing may be accepted.
      for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 1, 0, 0);

      // ON, then OFF ten cycles later.
      apply_stimulus(1'b1, 1'b1, 1, 0, 0);
      idle(9);
      apply_stimulus(1'b1, 1'b1, 0, 0, 0);
      idle(3);

      // BLINK with half=2, then half=0 behaving as half=1.
      apply_stimulus(1'b1, 1'b1, 2, 2, 0);
      idle(20);
      apply_stimulus(1'b1, 1'b1, 2, 0, 0);
      idle(12);

      // BURST of 3 with ON held valid throughout; ON lands in the done cycle.
      apply_stimulus(1'b1, 1'b1, 3, 1, 3);
      for (int i = 0; i < 30; i++) apply_stimulus(1'b1, 1'b1, 1, 0, 0);
      apply_stimulus(1'b1, 1'b1, 0, 0, 0);
      idle(2);

      // Empty burst.
      apply_stimulus(1'b1, 1'b1, 3, 1, 0);
      idle(3);

      // Reset in the middle of a burst.
      apply_stimulus(1'b1, 1'b1, 3, 2, 2);
      idle(5);
      apply_stimulus(1'b0, 1'b0, 0, 0, 0);
      idle(40);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         apply_stimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 5) == 0),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)));
      end
      idle(2);

      repeat (2) @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
